gin_feeder: RTL and testbench

Upstream driver for `gin_bus`. It owns the two things the global input network needs from its producer:
- the scan-chain programming sequence that loads a tag ID into every multicast controller;
- a small tagged-data FIFO whose head it presents to the bus as (`tag`, `input_value`, `enable`), popping an entry only when the addressed side reports ready.

It sits between the global buffer / loop controller and `gin_bus`.

---
 rtl/gin_pkg.sv | 21 ++
 rtl/gin_fifo.sv | 47 ++++
 rtl/gin_feeder.sv | 102 ++++++++++
 tb/tb_gin_feeder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gin_pkg.sv
// Shared definitions for the global input network: feeder FSM states,
// default bus widths and a constant-foldable clog2.
package gin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PROGRAM = 2'd1,
    ST_STREAM  = 2'd2
  } gin_state_e;

  localparam int GIN_BITWIDTH   = 16;
  localparam int GIN_TAG_LENGTH = 4;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/gin_fifo.sv
// Synchronous FIFO of packed {tag, value} words with full/empty/count.
// DEPTH must be a power of two so the pointers wrap for free.
module gin_fifo
  import gin_pkg::*;
#(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/gin_feeder.sv
// Producer side of gin_bus: runs the scan-chain tag programming pass and
// streams tagged words from a small FIFO onto the bus with ready handshake.
module gin_feeder
  import gin_pkg::*;
#(
  parameter int BITWIDTH        = GIN_BITWIDTH,
  parameter int TAG_LENGTH      = GIN_TAG_LENGTH,
  parameter int NUM_CONTROLLERS = 10,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic [TAG_LENGTH-1:0] cfg_tag,
  output logic                  cfg_ready,
  output logic                  cfg_done,
  input  logic                  in_valid,
  input  logic [TAG_LENGTH-1:0] in_tag,
  input  logic [BITWIDTH-1:0]   in_value,
  output logic                  in_ready,
  // `program` is a reserved word, hence the suffix on the bus strobe
  output logic                  program_en,
  output logic [TAG_LENGTH-1:0] scan_tag_out,
  output logic                  gin_enable,
  output logic [TAG_LENGTH-1:0] gin_tag,
  output logic [BITWIDTH-1:0]   gin_value,
  input  logic                  gin_ready,
  output logic                  busy
);

  localparam int CW = clog2(NUM_CONTROLLERS + 1);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int EW = TAG_LENGTH + BITWIDTH;

  typedef struct packed {
    logic [TAG_LENGTH-1:0] tag;
    logic [BITWIDTH-1:0]   value;
  } entry_t;

  gin_state_e    state, state_nxt;
  logic [CW-1:0] prog_cnt;
  logic          cfg_acc, last_tag;
  logic          push, pop, full, empty;
  logic [AW:0]   count;
  entry_t        head, wr_entry;

  assign cfg_ready = (state == ST_PROGRAM);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign last_tag  = cfg_acc && (prog_cnt == CW'(NUM_CONTROLLERS - 1));
  assign busy      = (state != ST_IDLE);

  // cfg_start wins over a same-cycle word in IDLE, so refuse the word
  assign in_ready   = !full && ((state == ST_STREAM) || (state == ST_IDLE && !cfg_start));
  assign push       = in_valid && in_ready;
  assign gin_enable = (state == ST_STREAM) && !empty;
  assign pop        = gin_enable && gin_ready;
  assign gin_tag    = gin_enable ? head.tag   : '0;
  assign gin_value  = gin_enable ? head.value : '0;
  assign wr_entry   = '{tag: in_tag, value: in_value};

  gin_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cfg_start) state_nxt = ST_PROGRAM;
                  else if (push) state_nxt = ST_STREAM;
      ST_PROGRAM: if (last_tag) state_nxt = ST_IDLE;
      ST_STREAM:  if (pop && !push && count == (AW+1)'(1)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      prog_cnt     <= '0;
      program_en   <= 1'b0;
      scan_tag_out <= '0;
      cfg_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      program_en <= cfg_acc;
      cfg_done   <= last_tag;
      if (cfg_acc) scan_tag_out <= cfg_tag;
      if (state == ST_IDLE && cfg_start) prog_cnt <= '0;
      else if (cfg_acc)                  prog_cnt <= prog_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gin_feeder.sv
// Directed, table-driven bench for gin_feeder with a gin_bus scan-chain model.
module tb_gin_feeder;

  typedef struct packed {
    logic        cfg_start;
    logic        cfg_valid;
    logic [3:0]  cfg_tag;
    logic        in_valid;
    logic [3:0]  in_tag;
    logic [15:0] in_value;
    logic        gin_ready;
  } ins_t;

  typedef struct packed {
    logic        cfg_ready;
    logic        cfg_done;
    logic        in_ready;
    logic        program_en;
    logic [3:0]  scan_tag_out;
    logic        gin_enable;
    logic [3:0]  gin_tag;
    logic [15:0] gin_value;
    logic        busy;
  } outs_t;

  typedef struct packed {
    ins_t  i;
    outs_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 0, cfg_valid = 0, in_valid = 0, gin_ready = 0;
  logic [3:0]  cfg_tag = 0, in_tag = 0;
  logic [15:0] in_value = 0;
  logic        cfg_ready, cfg_done, in_ready, program_en, gin_enable, busy;
  logic [3:0]  scan_tag_out, gin_tag;
  logic [15:0] gin_value;

  outs_t act;
  int    n_vec = 0;
  int    n_bad = 0;
  int    npulse = 0;
  logic [9:0][3:0] chain = '0;

  always #5 clk = ~clk;

  gin_feeder #(.BITWIDTH(16), .TAG_LENGTH(4), .NUM_CONTROLLERS(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_tag(cfg_tag),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_tag(in_tag), .in_value(in_value), .in_ready(in_ready),
    .program_en(program_en), .scan_tag_out(scan_tag_out),
    .gin_enable(gin_enable), .gin_tag(gin_tag), .gin_value(gin_value),
    .gin_ready(gin_ready), .busy(busy)
  );

  assign act = {cfg_ready, cfg_done, in_ready, program_en, scan_tag_out,
                gin_enable, gin_tag, gin_value, busy};

  // gin_bus scan chain: entry at [0], the first shifted tag ends at [9]
  always @(posedge clk) begin
    if (program_en === 1'b1) begin
      chain  <= {chain[8:0], scan_tag_out};
      npulse <= npulse + 1;
    end
  end

  function automatic ins_t din(logic v, logic [3:0] t, logic [15:0] val, logic gr);
    din = '0;
    din.in_valid  = v;
    din.in_tag    = t;
    din.in_value  = val;
    din.gin_ready = gr;
  endfunction

  function automatic outs_t so(logic inr, logic en, logic [3:0] t, logic [15:0] v, logic b);
    so = '0;
    so.in_ready   = inr;
    so.gin_enable = en;
    so.gin_tag    = t;
    so.gin_value  = v;
    so.busy       = b;
  endfunction

  task automatic apply(input ins_t x);
    cfg_start = x.cfg_start; cfg_valid = x.cfg_valid; cfg_tag = x.cfg_tag;
    in_valid  = x.in_valid;  in_tag    = x.in_tag;    in_value = x.in_value;
    gin_ready = x.gin_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_table(input string tname, input vec_t tbl[], input int n);
    for (int k = 0; k < n; k++) begin
      apply(tbl[k].i);
      #1;
      check($sformatf("%s[%0d]", tname, k), tbl[k].o);
      tick();
    end
  endtask

  task automatic run_pass(input string pname, input bit do_start, input int stall_at, input int stall_len);
    int acc_n = 0;
    int stall = 0;
    int p0;
    bit prev = 0;
    bit a;
    logic [3:0] es = 4'd0;
    logic [9:0][3:0] ec;
    ins_t x;
    outs_t e;
    if (do_start) begin
      x = '0; x.cfg_start = 1'b1;
      apply(x); #1;
      check({pname, " start"}, so(0, 0, 0, 0, 0));
      tick();
    end
    p0 = npulse;
    for (int c = 0; c < 40 && (acc_n < 10 || prev); c++) begin
      a = (acc_n < 10) && !(acc_n == stall_at && stall < stall_len);
      if (acc_n < 10 && !a) stall++;
      x = '0;
      x.cfg_valid = a;
      x.cfg_tag   = a ? 4'(9 - acc_n) : 4'hF;
      apply(x); #1;
      e = '0;
      e.cfg_ready    = (acc_n < 10);
      e.busy         = (acc_n < 10);
      e.in_ready     = !(acc_n < 10);
      e.program_en   = prev;
      e.scan_tag_out = es;
      e.cfg_done     = prev && (acc_n == 10);
      check($sformatf("%s c%0d", pname, c), e);
      prev = a;
      if (a) begin
        es = 4'(9 - acc_n);
        acc_n++;
      end
      tick();
    end
    apply('0); #1;
    check({pname, " idle"}, so(1, 0, 0, 0, 0));
    n_vec++;
    if (npulse - p0 != 10) begin
      n_bad++;
      $display("FAIL %s pulses: got %0d want 10", pname, npulse - p0);
    end
    for (int i = 0; i < 10; i++) ec[i] = 4'(i);
    n_vec++;
    if (chain !== ec) begin
      n_bad++;
      $display("FAIL %s chain: got %h want %h", pname, chain, ec);
    end
    tick();
  endtask

  vec_t  tbl_a[];
  vec_t  tbl_b[];
  ins_t  xi;
  outs_t xo;

  initial begin
    tbl_a = new[20];
    // three words at full throughput
    tbl_a[0]  = '{din(0, 0, 0, 0),      so(1, 0, 0, 0, 0)};
    tbl_a[1]  = '{din(1, 3, 13, 1),     so(1, 0, 0, 0, 0)};
    tbl_a[2]  = '{din(1, 1, 11, 1),     so(1, 1, 3, 13, 1)};
    tbl_a[3]  = '{din(1, 9, 19, 1),     so(1, 1, 1, 11, 1)};
    tbl_a[4]  = '{din(0, 0, 0, 1),      so(1, 1, 9, 19, 1)};
    tbl_a[5]  = '{din(0, 0, 0, 0),      so(1, 0, 0, 0, 0)};
    // five words against a stalled consumer, then drain
    tbl_a[6]  = '{din(1, 2, 100, 0),    so(1, 0, 0, 0, 0)};
    tbl_a[7]  = '{din(1, 4, 101, 0),    so(1, 1, 2, 100, 1)};
    tbl_a[8]  = '{din(1, 6, 102, 0),    so(1, 1, 2, 100, 1)};
    tbl_a[9]  = '{din(1, 8, 103, 0),    so(1, 1, 2, 100, 1)};
    tbl_a[10] = '{din(1, 10, 104, 0),   so(0, 1, 2, 100, 1)};
    tbl_a[11] = '{din(1, 10, 104, 0),   so(0, 1, 2, 100, 1)};
    tbl_a[12] = '{din(1, 10, 104, 1),   so(0, 1, 2, 100, 1)};
    tbl_a[13] = '{din(1, 10, 104, 1),   so(1, 1, 4, 101, 1)};
    tbl_a[14] = '{din(0, 0, 0, 1),      so(1, 1, 6, 102, 1)};
    tbl_a[15] = '{din(0, 0, 0, 1),      so(1, 1, 8, 103, 1)};
    tbl_a[16] = '{din(0, 0, 0, 1),      so(1, 1, 10, 104, 1)};
    tbl_a[17] = '{din(0, 0, 0, 0),      so(1, 0, 0, 0, 0)};
    // cfg_start collides with a word in IDLE
    xi = din(1, 5, 15, 1); xi.cfg_start = 1'b1;
    tbl_a[18] = '{xi,                   so(0, 0, 0, 0, 0)};
    xo = so(0, 0, 0, 0, 1); xo.cfg_ready = 1'b1;
    tbl_a[19] = '{din(0, 0, 0, 0),      xo};

    tbl_b = new[5];
    // cfg_start while streaming is ignored
    tbl_b[0] = '{din(1, 7, 77, 0),      so(1, 0, 0, 0, 0)};
    xi = din(0, 0, 0, 0); xi.cfg_start = 1'b1;
    tbl_b[1] = '{xi,                    so(1, 1, 7, 77, 1)};
    tbl_b[2] = '{din(0, 0, 0, 0),       so(1, 1, 7, 77, 1)};
    tbl_b[3] = '{din(0, 0, 0, 1),       so(1, 1, 7, 77, 1)};
    tbl_b[4] = '{din(0, 0, 0, 0),       so(1, 0, 0, 0, 0)};

    #2;
    check("reset", so(1, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;

    run_table("tblA", tbl_a, 20);
    run_pass("pass_nostall", 1'b0, 99, 0);
    run_pass("pass_stall", 1'b1, 4, 3);
    run_table("tblB", tbl_b, 5);

    // reset partway through a five-word stream
    for (int k = 0; k < 5; k++) begin
      apply(din(1, 4'(k + 1), 16'(200 + k), 0));
      tick();
    end
    apply('0);
    rst = 1'b1;
    #1;
    check("reset mid-stream", so(1, 0, 0, 0, 0));
    tick();
    rst = 1'b0;
    #1;
    check("post-reset idle", so(1, 0, 0, 0, 0));
    apply(din(1, 12, 300, 0));
    tick();
    apply(din(0, 0, 0, 0));
    #1;
    check("post-reset head", so(1, 1, 12, 300, 1));
    apply(din(0, 0, 0, 1));
    tick();
    #1;
    check("post-reset drain", so(1, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
